// File: rtl/rtc_access_sched.sv
// rtc_access_sched: arbitrates DS1302 time-read and WP-wrapped time-write bursts over one byte-transfer engine,
// publishing an atomic 56-bit time snapshot.
module rtc_access_sched #(
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdReq,
    input  logic        wrReq,
    input  logic [55:0] wrData,
    output logic        xferStart,
    output logic [7:0]  xferCmd,
    output logic [7:0]  xferWrData,
    output logic        xferRead,
    input  logic        xferDone,
    input  logic [7:0]  xferRdData,
    output logic [55:0] rdData,
    output logic        rdValid,
    output logic        wrDone,
    output logic        err,
    output logic        busy
);
    localparam logic [2:0] IDLE = 3'd0, WP_OFF = 3'd1, WR_REG = 3'd2, WP_ON = 3'd3, RD_REG = 3'd4, CMPL = 3'd5;
    localparam logic [1:0] ISSUE = 2'd0, WAIT = 2'd1, GAP = 2'd2;
    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [2:0]    state_q, state_d, idx_q, idx_d;
    logic [1:0]    ph_q, ph_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
    logic [55:0]   wr_shadow_q, wr_shadow_d, wr_work_q, wr_work_d, rd_buf_q, rd_buf_d, rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d, wr_done_q, wr_done_d, err_q, err_d;
    logic          xfer_st, wp_st, rd_st;
    logic [7:0]    wr_byte;

    assign xfer_st    = state_q inside {WP_OFF, WR_REG, WP_ON, RD_REG};
    assign wp_st      = state_q == WP_OFF || state_q == WP_ON;
    assign rd_st      = state_q == RD_REG;
    assign wr_byte    = wr_work_q[{idx_q, 3'b000} +: 8];
    assign busy       = state_q != IDLE;
    assign xferStart  = xfer_st && ph_q == ISSUE;
    assign xferRead   = rd_st;
    assign xferCmd    = !xfer_st ? 8'h00 : wp_st ? 8'h8E : {4'h8, idx_q, rd_st};
    // The seconds byte carries the clock-halt bit; always write it cleared so the oscillator runs.
    assign xferWrData = state_q == WP_ON ? 8'h80 :
                        state_q != WR_REG ? 8'h00 :
                        idx_q == 3'd0 ? {1'b0, wr_byte[6:0]} : wr_byte;
    assign rdData     = rd_data_q;
    assign rdValid    = rd_valid_q;
    assign wrDone     = wr_done_q;
    assign err        = err_q;

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q + CW'(1);
        rd_pend_d   = rd_pend_q | rdReq;
        wr_pend_d   = wr_pend_q | wrReq;
        wr_shadow_d = wrReq ? wrData : wr_shadow_q;
        wr_work_d   = wr_work_q;
        rd_buf_d    = rd_buf_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        wr_done_d   = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_pend_q) begin
                    state_d   = WP_OFF;
                    ph_d      = ISSUE;
                    idx_d     = 3'd0;
                    cnt_d     = '0;
                    wr_pend_d = wrReq;
                    wr_work_d = wr_shadow_q;
                end else if (rd_pend_q) begin
                    state_d   = RD_REG;
                    ph_d      = ISSUE;
                    idx_d     = 3'd0;
                    cnt_d     = '0;
                    rd_pend_d = rdReq;
                    rd_buf_d  = '0;
                end
            end
            CMPL: state_d = IDLE;
            default: begin
                case (ph_q)
                    ISSUE: ph_d = WAIT;
                    WAIT: begin
                        if (xferDone) begin
                            ph_d = GAP;
                            if (rd_st) rd_buf_d[{idx_q, 3'b000} +: 8] = xferRdData;
                        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        ph_d  = ISSUE;
                        cnt_d = '0;
                        idx_d = idx_q + 3'd1;
                        if (state_q == WP_OFF) begin
                            state_d = WR_REG;
                            idx_d   = 3'd0;
                        end else if (state_q == WP_ON) begin
                            state_d   = CMPL;
                            wr_done_d = 1'b1;
                        end else if (idx_q == 3'd6 && state_q == WR_REG) begin
                            state_d = WP_ON;
                            idx_d   = 3'd0;
                        end else if (idx_q == 3'd6) begin
                            state_d    = CMPL;
                            rd_valid_d = 1'b1;
                            rd_data_d  = rd_buf_q;
                        end
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ph_q        <= ISSUE;
            idx_q       <= '0;
            cnt_q       <= '0;
            rd_pend_q   <= 1'b0;
            wr_pend_q   <= 1'b0;
            wr_shadow_q <= '0;
            wr_work_q   <= '0;
            rd_buf_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            wr_done_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            rd_pend_q   <= rd_pend_d;
            wr_pend_q   <= wr_pend_d;
            wr_shadow_q <= wr_shadow_d;
            wr_work_q   <= wr_work_d;
            rd_buf_q    <= rd_buf_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            wr_done_q   <= wr_done_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_rtc_access_sched.sv
// tb_rtc_access_sched: directed bench acting as the DS1302 byte engine, checking command sequences,
// snapshot atomicity, arbitration, timeout and asynchronous reset.
module tb_rtc_access_sched;
    logic        clk = 1'b0, rst = 1'b1, rdReq = 1'b0, wrReq = 1'b0, xferDone = 1'b0;
    logic [55:0] wrData = '0;
    logic [7:0]  xferRdData = '0;
    logic        xferStart, xferRead, rdValid, wrDone, err, busy;
    logic [7:0]  xferCmd, xferWrData;
    logic [55:0] rdData;
    int checks = 0, errors = 0, rv_cnt = 0, wd_cnt = 0, err_cnt = 0, xs_cnt = 0;

    localparam logic [55:0] R1 = 56'h24031225123045;
    localparam logic [55:0] R2 = 56'h25123123595958;
    localparam logic [55:0] R3 = 56'h11223344556677;
    localparam logic [55:0] W1 = 56'h24031225123085;
    localparam logic [55:0] W2 = 56'h23061530224111;

    always #5 clk = ~clk;

    rtc_access_sched #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .rdReq(rdReq), .wrReq(wrReq), .wrData(wrData),
        .xferStart(xferStart), .xferCmd(xferCmd), .xferWrData(xferWrData), .xferRead(xferRead),
        .xferDone(xferDone), .xferRdData(xferRdData), .rdData(rdData), .rdValid(rdValid),
        .wrDone(wrDone), .err(err), .busy(busy)
    );

    always @(posedge clk) begin
        if (rdValid) rv_cnt++;
        if (wrDone) wd_cnt++;
        if (err) err_cnt++;
        if (xferStart) xs_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_start(input string tag, input logic [7:0] cmd, input logic rd);
        int n = 0;
        while (xferStart !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd1);
        chk({tag, "_cmd"}, 64'(xferCmd), 64'(cmd));
        chk({tag, "_rd"}, 64'(xferRead), 64'(rd));
    endtask

    task automatic serve(input string tag, input logic [7:0] cmd, input logic [7:0] wd, input logic rd,
                         input logic [7:0] rb, input logic poke);
        wait_start(tag, cmd, rd);
        if (!rd) chk({tag, "_wd"}, 64'(xferWrData), 64'(wd));
        rdReq = poke;
        tick();
        rdReq = 1'b0;
        xferDone = 1'b1;
        xferRdData = rb;
        tick();
        xferDone = 1'b0;
        xferRdData = 8'h00;
        chk({tag, "_gap"}, 64'(xferStart), 64'd0);
    endtask

    task automatic rd_burst(input logic [55:0] v);
        for (int i = 0; i < 7; i++) serve("rd", 8'h81 + 8'(2 * i), 8'h00, 1'b1, v[8*i +: 8], 1'b0);
    endtask

    task automatic wr_burst(input logic [55:0] v, input logic poke);
        serve("wpoff", 8'h8E, 8'h00, 1'b0, 8'h00, poke);
        for (int i = 0; i < 7; i++)
            serve("wr", 8'h80 + 8'(2 * i), i == 0 ? {1'b0, v[6:0]} : v[8*i +: 8], 1'b0, 8'h00, poke && i < 2);
        serve("wpon", 8'h8E, 8'h80, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        int xs0;
        tick();
        tick();
        chk("rst_outs", {busy, xferStart, xferRead, rdValid, wrDone, err, xferCmd, xferWrData, rdData}, 64'd0);
        rst = 1'b0;
        tick();
        xferDone = 1'b1;
        tick();
        xferDone = 1'b0;
        tick();
        chk("idle_done", {busy, xferStart}, 64'd0);

        rdReq = 1'b1;
        tick();
        rdReq = 1'b0;
        rd_burst(R1);
        chk("rd_pre", {busy, rdValid}, 64'b10);
        tick();
        chk("rd_valid", {busy, rdValid}, 64'b11);
        chk("rd_data", rdData, R1);
        tick();
        chk("rd_idle", {busy, rdValid}, 64'd0);
        chk("rd_cnt", rv_cnt, 1);

        wrData = W1;
        wrReq = 1'b1;
        tick();
        wrReq = 1'b0;
        wrData = '1;
        wr_burst(W1, 1'b0);
        tick();
        chk("wr_done", {busy, wrDone}, 64'b11);
        tick();
        chk("wr_idle", {busy, wrDone}, 64'd0);
        chk("wr_cnts", {32'(wd_cnt), 32'(rv_cnt)}, {32'd1, 32'd1});

        wrData = W2;
        wrReq = 1'b1;
        rdReq = 1'b1;
        tick();
        wrReq = 1'b0;
        rdReq = 1'b0;
        wr_burst(W2, 1'b1);
        tick();
        chk("sim_wrdone", wrDone, 1);
        tick();
        chk("sim_idle", {busy, xferStart}, 64'd0);
        rd_burst(R2);
        tick();
        chk("sim_rdvalid", rdValid, 1);
        chk("sim_rddata", rdData, R2);
        xs0 = xs_cnt;
        repeat (12) tick();
        chk("sim_one_read", {32'(rv_cnt), 32'(xs_cnt - xs0)}, {32'd2, 32'd0});
        chk("sim_quiet", busy, 0);

        rdReq = 1'b1;
        tick();
        rdReq = 1'b0;
        for (int i = 0; i < 3; i++) serve("to_rd", 8'h81 + 8'(2 * i), 8'h00, 1'b1, R3[8*i +: 8], 1'b0);
        wait_start("to_i3", 8'h87, 1'b1);
        repeat (15) tick();
        chk("to_early", {err, busy}, 64'b01);
        tick();
        chk("to_err", {err, busy}, 64'b10);
        chk("to_keep", rdData, R2);
        tick();
        chk("to_cnts", {32'(err_cnt), 32'(rv_cnt)}, {32'd1, 32'd2});
        chk("to_pulse", err, 0);

        wrData = W1;
        wrReq = 1'b1;
        tick();
        wrReq = 1'b0;
        serve("mr_wpoff", 8'h8E, 8'h00, 1'b0, 8'h00, 1'b0);
        serve("mr_wr0", 8'h80, 8'h05, 1'b0, 8'h00, 1'b0);
        serve("mr_wr1", 8'h82, 8'h30, 1'b0, 8'h00, 1'b0);
        wait_start("mr_wr2", 8'h84, 1'b0);
        tick();
        chk("mr_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mr_outs", {busy, xferStart, xferRead, rdValid, wrDone, err, xferCmd, xferWrData, rdData}, 64'd0);
        tick();
        rst = 1'b0;
        xs0 = xs_cnt;
        repeat (20) tick();
        chk("mr_quiet", {32'(xs_cnt - xs0), 31'd0, busy}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
